systolic_row_feeder: RTL

- Input-side neighbour of the systolic array: buffers matrix A and drives the array's left_in lanes.
- Each row's data is skewed diagonally. Row r is delayed r cycles, so operands meet B columns in the correct PE.
- Handshake is start / busy / done, so the top-level sequencer can launch a multiply and know when the A-stream has fully entered the array.

---
 rtl/tpu_pkg.sv | 19 +
 rtl/feeder_lane.sv | 60 ++++++
 rtl/systolic_row_feeder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic array front end.
//   DATA_W          default operand width
//   BEAT_W          width of the beat counter and of the K operand
//   data_t          one operand
//   feeder_state_t  row feeder sequencing states
package tpu_pkg;

  localparam int DATA_W = 8;
  localparam int BEAT_W = 8;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/feeder_lane.sv
// One row of the A buffer plus the skewed read select for that row.
// During beat t this lane presents A[LANE][t-LANE] when 0 <= t-LANE < k_len,
// otherwise exact zero.
//   clk        system clock
//   wr_en      write strobe, already qualified by row match and FSM state
//   wr_col     column (k) index of the write
//   wr_data    value written
//   beat       beat index being loaded into the output register
//   k_len      inner dimension of the stream being loaded
//   lane_data  combinational lane value for that beat
module feeder_lane #(
  parameter int LANE        = 0,
  parameter int SIZE_MATRIX = 4,
  parameter int DATA_W      = 8,
  parameter int COL_W       = 2,
  parameter int BEAT_W      = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BEAT_W-1:0] beat,
  input  logic [BEAT_W-1:0] k_len,
  output logic [DATA_W-1:0] lane_data
);

  // Buffer contents survive reset on purpose.
  logic [DATA_W-1:0] mem_q [SIZE_MATRIX];
  logic [BEAT_W-1:0] idx;
  logic              in_range;

  // Columns beyond SIZE_MATRIX never match an entry, so they are dropped.
  always_ff @(posedge clk) begin
    for (int j = 0; j < SIZE_MATRIX; j++) begin
      if (wr_en && (wr_col == COL_W'(j))) begin
        mem_q[j] <= wr_data;
      end
    end
  end

  assign idx      = beat - BEAT_W'(LANE);
  assign in_range = (beat >= BEAT_W'(LANE)) && (idx < k_len);

  // A write landing on the same edge as the read is forwarded, so a stream
  // launched together with a write sees the new value in beat 0.
  always_comb begin
    lane_data = '0;
    if (in_range) begin
      for (int j = 0; j < SIZE_MATRIX; j++) begin
        if (idx == BEAT_W'(j)) begin
          lane_data = mem_q[j];
          if (wr_en && (wr_col == COL_W'(j))) begin
            lane_data = wr_data;
          end
        end
      end
    end
  end

endmodule

// File: rtl/systolic_row_feeder.sv
// Buffers matrix A and streams it diagonally skewed into the array's
// left_in lanes (row r delayed by r beats).
//   clk, reset   system clock, synchronous active-high reset
//   wr_*         write one A element (accepted only while IDLE)
//   start,size_k launch a stream of K = size_k (1..SIZE_MATRIX)
//   left_out     registered lane values, one per array row
//   valid        high on stream beats
//   busy         high from beat 0 through the done cycle
//   done         one-cycle pulse after the last beat
//   err          one-cycle pulse for a rejected start
//
// state  | meaning
// IDLE   | waiting for start; buffer writable
// STREAM | presenting beat t_q; buffer frozen
// DONE   | done pulse cycle; start ignored
module systolic_row_feeder #(
  parameter  int ROW_NUMBER  = 4,
  parameter  int SIZE_MATRIX = 4,
  parameter  int DATA_W      = tpu_pkg::DATA_W,
  localparam int ROW_W       = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1,
  localparam int COL_W       = (SIZE_MATRIX > 1) ? $clog2(SIZE_MATRIX) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [ROW_W-1:0]                 wr_row,
  input  logic [COL_W-1:0]                 wr_col,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             start,
  input  logic [7:0]                       size_k,
  output logic [ROW_NUMBER-1:0][DATA_W-1:0] left_out,
  output logic                             valid,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  import tpu_pkg::feeder_state_t;
  import tpu_pkg::IDLE;
  import tpu_pkg::STREAM;
  import tpu_pkg::DONE;
  import tpu_pkg::BEAT_W;

  feeder_state_t state_q, state_d;
  logic [BEAT_W-1:0] t_q, t_d;
  logic [BEAT_W-1:0] k_q, k_d;
  logic [BEAT_W-1:0] beat_sel;
  logic [BEAT_W-1:0] t_last;
  logic              load_beat;
  logic              k_legal;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ROW_NUMBER-1:0]             lane_we;
  logic [ROW_NUMBER-1:0][DATA_W-1:0] lane_data;
  logic [ROW_NUMBER-1:0][DATA_W-1:0] left_out_q, left_out_d;

  assign k_legal = (size_k != 8'd0) && (size_k <= BEAT_W'(SIZE_MATRIX));
  assign t_last  = k_q + BEAT_W'(ROW_NUMBER) - BEAT_W'(2);

  // Outputs are registered, so the comb block selects the beat that will be
  // visible after the coming edge (beat_sel), not the one on display now.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    k_d       = k_q;
    beat_sel  = t_q;
    load_beat = 1'b0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (k_legal) begin
            state_d   = STREAM;
            t_d       = '0;
            k_d       = size_k;
            beat_sel  = '0;
            load_beat = 1'b1;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        busy_d = 1'b1;
        if (t_q == t_last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          t_d       = t_q + BEAT_W'(1);
          beat_sel  = t_q + BEAT_W'(1);
          load_beat = 1'b1;
          valid_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        t_d     = '0;
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  assign left_out_d = load_beat ? lane_data : '0;

  for (genvar r = 0; r < ROW_NUMBER; r++) begin : g_lane
    assign lane_we[r] = wr_en && (state_q == IDLE) && (wr_row == ROW_W'(r));

    feeder_lane #(
      .LANE        (r),
      .SIZE_MATRIX (SIZE_MATRIX),
      .DATA_W      (DATA_W),
      .COL_W       (COL_W),
      .BEAT_W      (BEAT_W)
    ) u_lane (
      .clk       (clk),
      .wr_en     (lane_we[r]),
      .wr_col    (wr_col),
      .wr_data   (wr_data),
      .beat      (beat_sel),
      .k_len     (k_d),
      .lane_data (lane_data[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      t_q        <= '0;
      k_q        <= '0;
      left_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      k_q        <= k_d;
      left_out_q <= left_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign left_out = left_out_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
